// File: rtl/arith_pkg.sv
// Shared op-code encoding and flag layout for the pipelined arithmetic unit.
// The flag vector is {C,V,Z,N}, with C at bit 3 and N at bit 0.
package arith_pkg;

    localparam logic [2:0] OP_PASS_A = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SUB_AB = 3'd2;
    localparam logic [2:0] OP_SUB_BA = 3'd3;
    localparam logic [2:0] OP_NEG_A  = 3'd4;
    localparam logic [2:0] OP_INC_A  = 3'd5;
    localparam logic [2:0] OP_SUB3_A = 3'd6;
    localparam logic [2:0] OP_ADD2_B = 3'd7;

    localparam int FLAG_C  = 3;
    localparam int FLAG_V  = 2;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_N  = 0;
    localparam int FLAGS_W = 4;

    function automatic logic [FLAGS_W-1:0] pack_flags(input logic c, input logic v,
                                                      input logic z, input logic n);
        logic [FLAGS_W-1:0] f;
        f         = 4'b0000;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        return f;
    endfunction

endpackage

// File: rtl/arith_pipe_unit_if.sv
// Operand/result handshake bundle for arith_pipe_unit.
// The unit connects through the slave modport; the operand source/consumer uses master.
interface arith_pipe_unit_if
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         opselect;
    logic [WIDTH-1:0]   OpA;
    logic [WIDTH-1:0]   OpB;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [FLAGS_W-1:0] flags;
    logic [TAG_W-1:0]   out_tag;

    modport slave (
        input  in_valid, opselect, OpA, OpB, in_tag, out_ready,
        output in_ready, out_valid, result, flags, out_tag
    );

    modport master (
        output in_valid, opselect, OpA, OpB, in_tag, out_ready,
        input  in_ready, out_valid, result, flags, out_tag
    );
endinterface

// File: rtl/arith_core.sv
// Combinational compute of result and {C,V,Z,N} for one operation.
// Optional build macro ARITH_SAT_EN: saturate to the signed limit on overflow.
module arith_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [FLAGS_W-1:0] flags_o
);

    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] y_s;
    logic             sub_s;
    logic             arith_s;
    logic [WIDTH:0]   wide_s;
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;

`ifdef ARITH_SAT_EN
    // On overflow the true result carries the sign of the minuend/addend x.
    function automatic logic [WIDTH-1:0] sat_limit(input logic x_neg);
        logic [WIDTH-1:0] lim;
        if (x_neg) begin
            lim = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            lim = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return lim;
    endfunction
`endif

    // Map each op onto a single add-or-subtract of x and y.
    always_comb begin
        x_s     = a_i;
        y_s     = {WIDTH{1'b0}};
        sub_s   = 1'b0;
        arith_s = 1'b1;
        case (op_i)
            OP_PASS_A: arith_s = 1'b0;
            OP_ADD:    y_s = b_i;
            OP_SUB_AB: begin y_s = b_i; sub_s = 1'b1; end
            OP_SUB_BA: begin x_s = b_i; y_s = a_i; sub_s = 1'b1; end
            OP_NEG_A:  begin x_s = {WIDTH{1'b0}}; y_s = a_i; sub_s = 1'b1; end
            OP_INC_A:  y_s = WIDTH'(1);
            OP_SUB3_A: begin y_s = WIDTH'(3); sub_s = 1'b1; end
            OP_ADD2_B: begin x_s = b_i; y_s = WIDTH'(2); end
            default:   arith_s = 1'b0;
        endcase
    end

    // The extra top bit is the carry for adds and the borrow for subtracts.
    always_comb begin
        if (sub_s) begin
            wide_s = {1'b0, x_s} - {1'b0, y_s};
        end else begin
            wide_s = {1'b0, x_s} + {1'b0, y_s};
        end
        raw_s = wide_s[WIDTH-1:0];
        c_s   = arith_s & wide_s[WIDTH];
        v_s   = arith_s
              & ((x_s[WIDTH-1] ^ y_s[WIDTH-1]) == sub_s)
              & (raw_s[WIDTH-1] != x_s[WIDTH-1]);
    end

    // Final result selection and flag packing.
    always_comb begin
`ifdef ARITH_SAT_EN
        if (v_s) begin
            res_s = sat_limit(x_s[WIDTH-1]);
        end else begin
            res_s = raw_s;
        end
`else
        res_s = raw_s;
`endif
        result_o = res_s;
        flags_o  = pack_flags(c_s, v_s, (res_s == {WIDTH{1'b0}}), res_s[WIDTH-1]);
    end

endmodule

// File: rtl/arith_pipe_unit.sv
// Two-stage valid/ready arithmetic pipeline: S1 registers the operation, S2 registers
// the computed result, flags and tag. Build macro ARITH_SAT_EN selects saturating results.
module arith_pipe_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    arith_pipe_unit_if.slave  bus
);

    logic               s1_valid_q, s1_valid_d;
    logic [2:0]         s1_op_q,    s1_op_d;
    logic [WIDTH-1:0]   s1_a_q,     s1_a_d;
    logic [WIDTH-1:0]   s1_b_q,     s1_b_d;
    logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic [FLAGS_W-1:0] flags_q,     flags_d;
    logic [TAG_W-1:0]   out_tag_q,   out_tag_d;

    logic               s2_adv_s;
    logic               s1_adv_s;
    logic [WIDTH-1:0]   core_result_s;
    logic [FLAGS_W-1:0] core_flags_s;

    arith_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .result_o (core_result_s),
        .flags_o  (core_flags_s)
    );

    // Stage advance conditions; built only from registered state and out_ready.
    always_comb begin
        s2_adv_s = !out_valid_q || bus.out_ready;
        s1_adv_s = !s1_valid_q || s2_adv_s;
    end

    // S1 next state: load a new op when advancing, otherwise hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        if (s1_adv_s) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_op_d  = bus.opselect;
                s1_a_d   = bus.OpA;
                s1_b_d   = bus.OpB;
                s1_tag_d = bus.in_tag;
            end else begin
                s1_op_d  = s1_op_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: output data only changes when a valid op moves in.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_tag_d   = out_tag_q;
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d  = core_result_s;
                flags_d   = core_flags_s;
                out_tag_d = s1_tag_q;
            end else begin
                result_d  = result_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 3'd0;
            s1_a_q      <= {WIDTH{1'b0}};
            s1_b_q      <= {WIDTH{1'b0}};
            s1_tag_q    <= {TAG_W{1'b0}};
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            flags_q     <= {FLAGS_W{1'b0}};
            out_tag_q   <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.in_ready  = s1_adv_s;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: doc/arith_pipe_unit.md
Name: arith_pipe_unit

Overview:
- Parametrised, pipelined successor to the 8-bit combinational arithmetic circuit.
- Keeps the same 3-bit opselect encoding, with operand width generalised to WIDTH.
- Adds a valid/ready handshake on input and output, a pass-through tag, and registered status flags (C, V, Z, N).
- Sits between the operand source (ROM or sequencer) and the result consumer (LED/display or register file); sustains one operation per cycle under no backpressure.

Parameters:
- WIDTH, 8: operand and result width in bits; legal values are 4 or greater.
- TAG_W, 4: width of the user tag carried alongside each operation; legal values are 1 or greater.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented on opselect/OpA/OpB/in_tag.
- in_ready  out  1  unit accepts the operation this cycle.
- opselect  in  3  operation code (see Behaviour).
- OpA  in  WIDTH  operand A.
- OpB  in  WIDTH  operand B.
- in_tag  in  TAG_W  user tag, returned unchanged with the result.
- out_valid  out  1  result, flags and out_tag are valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  operation result.
- flags  out  4  {C,V,Z,N}; bit 3 is C, bit 0 is N.
- out_tag  out  TAG_W  tag of the operation currently on result.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, result=0, flags=0, out_tag=0.
  - Both pipeline stages are emptied.
  - in_ready=1 from the first cycle after rst_n deasserts.
  - Reset asserted mid-stream discards all in-flight operations; nothing is emitted afterwards.
- Operations (all modulo 2^WIDTH; constants zero-extended to WIDTH):
  - 0: A.
  - 1: A+B.
  - 2: A-B.
  - 3: B-A.
  - 4: 0-A.
  - 5: A+1.
  - 6: A-3.
  - 7: B+2.
- Flags:
  - C, add ops (1,5,7): carry-out of the unsigned add.
  - C, subtract ops (2,3,4,6): borrow, i.e. minuend < subtrahend, unsigned.
  - C for op 0 is 0.
  - V: two's-complement signed overflow of the operation; 0 for op 0.
  - Z: result==0, evaluated on the final (possibly saturated) result.
  - N: result MSB.
- Pipeline:
  - Stage S1 registers opselect, OpA, OpB and in_tag.
  - Stage S2 computes and registers result, flags and out_tag.
  - Latency is exactly 2 cycles from the accepting edge (in_valid & in_ready) to out_valid, absent stalls.
- Handshake:
  - Advance S2 when (!out_valid | out_ready).
  - Advance S1 when (!s1_valid | S2 advances).
  - in_ready = that S1 advance condition.
  - in_ready must not depend combinationally on in_valid.
  - out_valid, result, flags and out_tag hold stable while out_valid & !out_ready.
  - No operation is dropped or duplicated; output order equals acceptance order.
- Simultaneous accept on input and take on output in the same cycle is legal. The pipe shifts by one with no bubble, so full throughput is 1 op per cycle.
- Capacity: 2 operations in flight. A stalled full pipe holds in_ready=0 until out_ready=1.
- Unused input values are ignored while in_valid=0; S1 keeps no stale valid.

Optional Feature:
- Macro: ARITH_SAT_EN.
- With the macro defined: when V would be 1, result saturates to the signed limit in the direction of the true result (max positive 0111..1 or min negative 1000..0). V still reports 1. Z and N reflect the saturated value.
- Without the macro: the result wraps modulo 2^WIDTH, matching the previous generation bit-for-bit for WIDTH=8.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package arith_pkg holds:
  - the op-code constants OP_PASS_A, OP_ADD, OP_SUB_AB, OP_SUB_BA, OP_NEG_A, OP_INC_A, OP_SUB3_A, OP_ADD2_B;
  - flag bit indices FLAG_C=3, FLAG_V=2, FLAG_Z=1, FLAG_N=0.
- Sub-module arith_core: purely combinational, WIDTH-parametrised compute of result and flags (including saturation). It is instantiated in S2.
- The top level holds the two register stages and the handshake logic.

Test Plan (WIDTH=8):
- Reset, then idle -> out_valid=0, result=0x00, flags=0x0, in_ready=1. Assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately; no output after release.
- op1, A=0xFF, B=0x01, tag=5 -> two cycles later result=0x00, flags C=1 Z=1 V=0 N=0, out_tag=5.
- op2, A=0x80, B=0x01 -> without macro: result=0x7F, V=1, C=0, N=0. With ARITH_SAT_EN: result=0x80, V=1, N=1.
- op4, A=0x80 -> without macro: result=0x80, V=1, C=1, N=1. With ARITH_SAT_EN: 0x7F. op6, A=0x02 -> result=0xFF, C=1, V=0, N=1.
- Backpressure: hold out_ready=0 while offering ops with tags 1,2,3 -> only tags 1,2 accepted and in_ready=0 thereafter. Outputs stay stable. Release out_ready -> tags 1,2,3 emerge in order with no loss or duplication.
- Streaming: in_valid=1 and out_ready=1 for 16 cycles with all 8 opcodes and random operands -> 16 results on consecutive cycles, each matching the reference model at 2-cycle latency.
